opacc_seq: RTL

OPACC_SEQ -- requirements
Module: opacc_seq

---
 rtl/opacc_pkg.sv | 19 +
 rtl/opacc_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/opacc_pkg.sv
// Shared definitions for the outer-product accumulator sequencer:
// command op-codes and the sequencer FSM state encoding.
package opacc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_MAC   = 2'd1,
    OP_STORE = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MAC   = 2'd2,
    S_STORE = 2'd3
  } state_t;

endpackage

// File: rtl/opacc_seq.sv
// Command sequencer for an outer-product accumulator cell.
// Takes one command at a time, steers the operand stream into the cell
// (LOAD writes a C register, MAC accumulates K products into it) and
// streams a C register back out on STORE.
//
// Handshakes: every stream (cmd, in, out) transfers a beat on a rising
// clock edge where valid and ready are both high. A producer holds valid
// and its payload steady until that edge; ready never depends on valid.
//
// The FSM always returns to IDLE for at least one cycle after a command,
// so a STORE issued right after a LOAD/MAC reads co one cycle after the
// final cell write has landed.
module opacc_seq
  import opacc_pkg::*;
#(
  parameter int nregs = 2,
  parameter int XLEN  = 64,
  parameter int KMAX  = 255,
  localparam int LW   = $clog2(KMAX + 1),
  localparam int AW   = $clog2(nregs)
) (
  input  logic            clk,
  input  logic            reset,
  // command stream
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  // operand stream
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_c,
  // result stream
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_c,
  output logic            done,
  // cell side
  output logic            ab_valid,
  output logic            ci_valid,
  output logic [XLEN-1:0] ai,
  output logic [XLEN-1:0] bj,
  output logic [XLEN-1:0] ci,
  output logic [AW-1:0]   cld_addr,
  output logic [AW-1:0]   cst_addr,
  output logic [AW-1:0]   ab_addr,
  input  logic [XLEN-1:0] co,
  // debug view of the FSM
  output logic [1:0]      state_dbg
);

  state_t        state;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] cnt_q;

  // Sequencer FSM: accepts commands in IDLE, counts operand beats, and
  // produces a registered one-cycle done pulse after each command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            cnt_q  <= cmd_len;
            case (op_e'(cmd_op))
              OP_LOAD:  state <= S_LOAD;
              OP_MAC: begin
                // A zero-length MAC has nothing to stream; retire it at once.
                if (cmd_len != '0) state <= S_MAC;
                else               done  <= 1'b1;
              end
              OP_STORE: state <= S_STORE;
              default:  done  <= 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_MAC: begin
          // Gaps in in_valid simply stall the count.
          if (in_valid) begin
            cnt_q <= cnt_q - LW'(1);
            if (cnt_q == LW'(1)) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_STORE: begin
          if (out_ready) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and cell strobes decoded from the registered state; the
  // cell write strobes are exclusive because LOAD and MAC are distinct states.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    in_ready  = (state == S_LOAD) || (state == S_MAC);
    out_valid = (state == S_STORE);
    ci_valid  = (state == S_LOAD) && in_valid;
    ab_valid  = (state == S_MAC) && in_valid;
  end

  assign ai        = in_a;
  assign bj        = in_b;
  assign ci        = in_c;
  assign out_c     = co;
  assign cld_addr  = addr_q;
  assign cst_addr  = addr_q;
  assign ab_addr   = addr_q;
  assign state_dbg = state;

endmodule
